// File: rtl/tier2_ram_reader_pkg.sv
// Shared tier2 definitions: default RAM geometry and the reader state encoding.
package tier2_ram_reader_pkg;

  localparam int T2_ADDR_WIDTH = 14;
  localparam int T2_WORD_WIDTH = 18;
  localparam int T2_DEPTH      = 12288;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/tier2_skid_fifo.sv
// Two-entry FIFO that holds words captured from the RAM until downstream
// accepts them.
// Ports:
//   clk, rst  clock, async active-high reset
//   push, din capture a word (caller guarantees space, counting a same-cycle pop)
//   pop       remove the head word (ignored when empty)
//   dout      head word, 0 when empty
//   count     occupancy 0..2
module tier2_skid_fifo #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head, tail;
  logic             pop_eff;

  assign pop_eff = pop && (count != 2'd0);
  assign dout    = (count != 2'd0) ? head : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop_eff})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Head leaves; the new word lands behind whatever remains.
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tier2_ram_reader.sv
// Reads a burst of words from a RAM port shared with a writer and streams them
// out through a 2-entry FIFO with valid/ready handshake.
// Ports:
//   rd_clk, rst_syn            clock, async active-high reset
//   start, start_addr, word_count  burst request (sampled in IDLE only)
//   lram_write_en              writer strobe; the writer owns the port when high
//   laddr_rd, lram_read_en     RAM read request
//   ldata_ram                  RAM data, valid the cycle after an issued read
//   out_data, out_valid, out_ready  output stream
//   busy, done                 burst status
module tier2_ram_reader
  import tier2_ram_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = T2_ADDR_WIDTH,
  parameter int WORD_WIDTH = T2_WORD_WIDTH,
  parameter int DEPTH      = T2_DEPTH
) (
  input  logic                  rd_clk,
  input  logic                  rst_syn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  input  logic                  lram_write_en,
  output logic [ADDR_WIDTH-1:0] laddr_rd,
  output logic                  lram_read_en,
  input  logic [WORD_WIDTH-1:0] ldata_ram,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic                  inflight;
  logic [1:0]            occ;
  logic [1:0]            net_occ;
  logic [2:0]            pending;
  logic                  pop;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign pop     = out_valid && out_ready;
  // Occupancy net of this cycle's pop: lets a read issue while the head word
  // leaves, which is what sustains one word per cycle.
  assign net_occ = occ - {1'b0, pop};
  assign pending = {1'b0, net_occ} + {2'b00, inflight};

  assign issue = (state == ST_READ) && (remaining != '0) && !lram_write_en &&
                 (pending < 3'd2);

  assign lram_read_en = issue;
  assign laddr_rd     = issue ? addr : '0;
  assign out_valid    = (occ != 2'd0);

  assign next_addr = (addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr + ADDR_WIDTH'(1);

  // The in-flight flag doubles as the capture strobe for the RAM's 1-cycle data.
  tier2_skid_fifo #(.WIDTH(WORD_WIDTH)) u_fifo (
    .clk   (rd_clk),
    .rst   (rst_syn),
    .push  (inflight),
    .din   (ldata_ram),
    .pop   (pop),
    .dout  (out_data),
    .count (occ)
  );

  always_ff @(posedge rd_clk or posedge rst_syn) begin
    if (rst_syn) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      inflight <= issue;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr      <= start_addr;
            remaining <= word_count;
            if (word_count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_READ;
              busy  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            addr      <= next_addr;
            remaining <= remaining - ADDR_WIDTH'(1);
            if (remaining == ADDR_WIDTH'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Leave on the edge that pops the final word.
          if (!inflight && net_occ == 2'd0) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tier2_ram_reader.sv
module tb_tier2_ram_reader;

  localparam int AW    = 14;
  localparam int WW    = 18;
  localparam int DEPTH = 12288;

  logic          clk = 1'b0;
  logic          rst_syn;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] word_count;
  logic          lram_write_en;
  logic [AW-1:0] laddr_rd;
  logic          lram_read_en;
  logic [WW-1:0] ldata_ram = '0;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  tier2_ram_reader dut (
    .rd_clk        (clk),
    .rst_syn       (rst_syn),
    .start         (start),
    .start_addr    (start_addr),
    .word_count    (word_count),
    .lram_write_en (lram_write_en),
    .laddr_rd      (laddr_rd),
    .lram_read_en  (lram_read_en),
    .ldata_ram     (ldata_ram),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, fixed random contents.
  logic [WW-1:0] ram [0:DEPTH-1];
  always @(posedge clk) if (lram_read_en) ldata_ram <= ram[laddr_rd];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard state, filled by the monitor.
  logic [WW-1:0] got_q[$];
  int            addr_q[$];
  int            rd_cyc_q[$];
  int            pop_cyc_q[$];
  int            reads_n, pops_n, done_cnt, done_cyc, first_valid_cyc, start_edge;
  logic          stall_prev = 1'b0;
  logic [WW-1:0] stall_data;

  task automatic clear_sb();
    got_q.delete(); addr_q.delete(); rd_cyc_q.delete(); pop_cyc_q.delete();
    reads_n = 0; pops_n = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (rst_syn) begin
      stall_prev = 1'b0;
    end else begin
      if (lram_write_en) check("no_read_on_write", {31'd0, lram_read_en}, 32'd0);
      if (stall_prev) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {14'd0, out_data}, {14'd0, stall_data});
      end
      if (lram_read_en) begin
        addr_q.push_back(int'(laddr_rd));
        rd_cyc_q.push_back(cyc);
        reads_n++;
        check("buffered_le2",
              {31'd0, (reads_n - pops_n - ((out_valid && out_ready) ? 1 : 0)) <= 2}, 32'd1);
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        pop_cyc_q.push_back(cyc);
        pops_n++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_busy_low", {31'd0, busy}, 32'd0);
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"},  {31'd0, lram_read_en}, 32'd0);
    check({tag, "_addr"},   {18'd0, laddr_rd}, 32'd0);
    check({tag, "_valid"},  {31'd0, out_valid}, 32'd0);
    check({tag, "_data"},   {14'd0, out_data}, 32'd0);
    check({tag, "_busy"},   {31'd0, busy}, 32'd0);
    check({tag, "_done"},   {31'd0, done}, 32'd0);
  endtask

  // mode 0: ready=1; 1: write for 3 cycles; 2: ready=0 for 10 cycles;
  // 3: random ready/write plus stray start pulses.
  task automatic run_burst(input int sa, input int cnt, input int mode);
    int n;
    clear_sb();
    @(posedge clk); #1;
    start = 1'b1; start_addr = AW'(sa); word_count = AW'(cnt); start_edge = cyc + 1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cnt != 0) break;
      case (mode)
        1: lram_write_en = (k >= 2 && k < 5);
        2: out_ready = !(k >= 1 && k < 11);
        3: begin
          out_ready     = ($urandom_range(0, 3) != 0);
          lram_write_en = ($urandom_range(0, 4) == 0);
          start         = ($urandom_range(0, 5) == 0);
          start_addr    = AW'($urandom);
          word_count    = AW'($urandom);
        end
        default: ;
      endcase
    end
    start = 1'b0; out_ready = 1'b1; lram_write_en = 1'b0;
    check("done_seen", {31'd0, done_cnt != 0}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    check("done_once", done_cnt, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("word_total", got_q.size(), cnt);
    check("read_total", addr_q.size(), cnt);
    n = (got_q.size() < cnt) ? got_q.size() : cnt;
    for (int i = 0; i < n; i++)
      check("word", {14'd0, got_q[i]}, {14'd0, ram[(sa + i) % DEPTH]});
    n = (addr_q.size() < cnt) ? addr_q.size() : cnt;
    for (int i = 0; i < n; i++)
      check("rd_addr", addr_q[i], (sa + i) % DEPTH);
    if (mode == 0 && cnt > 0 && addr_q.size() == cnt && got_q.size() == cnt) begin
      check("start_latency", first_valid_cyc - start_edge, 32'd2);
      check("rd_back_to_back", rd_cyc_q[cnt-1] - rd_cyc_q[0], cnt - 1);
      check("pop_back_to_back", pop_cyc_q[cnt-1] - pop_cyc_q[0], cnt - 1);
      check("done_after_pop", done_cyc - pop_cyc_q[cnt-1], 32'd1);
    end
    if (cnt == 0) check("zero_done_cycle", done_cyc - start_edge, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = WW'($urandom);
    rst_syn = 1'b1; start = 1'b0; start_addr = '0; word_count = '0;
    lram_write_en = 1'b0; out_ready = 1'b1;
    clear_sb();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_syn = 1'b0;

    run_burst(16'h0010, 4, 0);       // plain burst
    run_burst(12286, 4, 0);          // wrap at DEPTH-1
    run_burst(200, 8, 1);            // writer collision
    run_burst(500, 8, 2);            // backpressure
    run_burst(700, 0, 0);            // zero count
    run_burst(12287, 1, 0);          // single word at top address

    // Reset mid-burst after 3 words, then a clean burst.
    clear_sb();
    @(posedge clk); #1;
    start = 1'b1; start_addr = AW'(1000); word_count = AW'(8);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (pops_n >= 3) break;
      @(posedge clk); #1;
    end
    check("pre_reset_pops", {31'd0, pops_n >= 3}, 32'd1);
    rst_syn = 1'b1;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    check_outputs_zero("midreset_edge");
    @(posedge clk); #1;
    rst_syn = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("midreset_no_done", done_cnt, 32'd0);
    run_burst(3000, 8, 0);

    // Randomized bursts, one of them near the wrap point.
    run_burst(12280, 15, 3);
    for (int t = 0; t < 6; t++)
      run_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 20), 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
